// File: rtl/lumped_sweep_ctrl_if.sv
// Config, handshake and bank-drive bundle for lumped_sweep_ctrl.
// The master side is the register file/measurement block, and the slave side is the sequencer.
interface lumped_sweep_ctrl_if #(
  parameter int unsigned CODE_W  = 6,
  parameter int unsigned DWELL_W = 16
);
  logic [CODE_W-1:0]  cfg_start;
  logic [CODE_W-1:0]  cfg_stop;
  logic [CODE_W-1:0]  cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               go;
  logic               abort;
  logic               meas_ack;
  logic [CODE_W-1:0]  bank_code;
  logic               bank_en;
  logic               meas_req;
  logic [CODE_W-1:0]  point_idx;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output cfg_start, cfg_stop, cfg_step, cfg_dwell, go, abort, meas_ack,
    input  bank_code, bank_en, meas_req, point_idx, busy, done, err
  );

  modport slave (
    input  cfg_start, cfg_stop, cfg_step, cfg_dwell, go, abort, meas_ack,
    output bank_code, bank_en, meas_req, point_idx, busy, done, err
  );
endinterface

// File: rtl/lumped_sweep_ctrl.sv
// Lumped-element bank sweep sequencer: apply code, settle, measure handshake, step.
// Optional measurement timeout with sticky err: define LUMPED_SWEEP_TIMEOUT_EN.
module lumped_sweep_ctrl #(
  parameter int unsigned CODE_W  = 6,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned TO_W    = 12
) (
  input logic                clk,
  input logic                rst,
  lumped_sweep_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, APPLY, SETTLE, MEASURE, NEXT, DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   cur_q, cur_d;
  logic [CODE_W-1:0]   stop_q, stop_d;
  logic [CODE_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0]   bank_code_q, bank_code_d;
  logic                bank_en_q, bank_en_d;
  logic                meas_req_q, meas_req_d;
  logic [CODE_W-1:0]   point_idx_q, point_idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [CODE_W-1:0]   step_eff;
  logic [CODE_W:0]     nxt;

`ifdef LUMPED_SWEEP_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign step_eff = (step_q == '0) ? CODE_W'(1) : step_q;
  // One extra bit so a step past 2^CODE_W-1 is seen as overflow, not a wrap
  assign nxt      = {1'b0, cur_q} + {1'b0, step_eff};

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    bank_code_d = bank_code_q;
    bank_en_d   = bank_en_q;
    meas_req_d  = meas_req_q;
    point_idx_d = point_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef LUMPED_SWEEP_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.go && !bus.abort) begin
          cur_d       = bus.cfg_start;
          stop_d      = bus.cfg_stop;
          step_d      = bus.cfg_step;
          dwell_d     = bus.cfg_dwell;
          point_idx_d = '0;
          busy_d      = 1'b1;
          err_d       = 1'b0;
          state_d     = APPLY;
        end
      end
      APPLY: begin
        bank_code_d = cur_q;
        bank_en_d   = 1'b1;
        cnt_d       = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
        state_d     = SETTLE;
      end
      SETTLE: begin
        if (cnt_q <= DWELL_W'(1)) begin
          meas_req_d = 1'b1;
`ifdef LUMPED_SWEEP_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
          state_d    = MEASURE;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      MEASURE: begin
        if (bus.meas_ack) begin
          meas_req_d = 1'b0;
          state_d    = NEXT;
        end
`ifdef LUMPED_SWEEP_TIMEOUT_EN
        // Ack has priority, so an ack on the saturating cycle still counts as success
        else if (to_cnt_q == TO_LAST) begin
          to_cnt_d   = '1;
          err_d      = 1'b1;
          meas_req_d = 1'b0;
          state_d    = NEXT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      NEXT: begin
        if ((cur_q >= stop_q) || (nxt > {1'b0, stop_q}) || nxt[CODE_W]) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cur_d       = nxt[CODE_W-1:0];
          point_idx_d = point_idx_q + CODE_W'(1);
          state_d     = APPLY;
        end
      end
      DONE: begin
        bank_en_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      bank_en_d  = 1'b0;
      meas_req_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      bank_code_q <= '0;
      bank_en_q   <= 1'b0;
      meas_req_q  <= 1'b0;
      point_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LUMPED_SWEEP_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      bank_code_q <= bank_code_d;
      bank_en_q   <= bank_en_d;
      meas_req_q  <= meas_req_d;
      point_idx_q <= point_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef LUMPED_SWEEP_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign bus.bank_code = bank_code_q;
  assign bus.bank_en   = bank_en_q;
  assign bus.meas_req  = meas_req_q;
  assign bus.point_idx = point_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef LUMPED_SWEEP_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: doc/lumped_sweep_ctrl.md
Name: lumped_sweep_ctrl

Overview:
- Sequencer for a digitally switched lumped-element bank: a capacitor array, amplifier gain taps, or transformer taps.
- Steps the bank code from a start value to a stop value in fixed increments.
- After each step, waits a programmable settling dwell, then handshakes with the measurement block before moving on.
- Sits between the test/config register file and the lumped bank's switch decoder.

Parameters:
- CODE_W, 6, width of the bank code, start/stop/step fields and point index.
- DWELL_W, 16, width of the settling dwell counter.
- TO_W, 12, width of the measurement timeout counter. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- cfg_start  in  CODE_W  first bank code.
- cfg_stop  in  CODE_W  last bank code (inclusive bound).
- cfg_step  in  CODE_W  code increment; 0 is treated as 1.
- cfg_dwell  in  DWELL_W  settling cycles per point; 0 is treated as 1.
- go  in  1  start-sweep pulse; sampled only in IDLE.
- abort  in  1  terminate the sweep; highest priority after rst.
- meas_ack  in  1  measurement complete for the current point.
- bank_code  out  CODE_W  code driven to the switch decoder.
- bank_en  out  1  bank switches enabled.
- meas_req  out  1  request a measurement at the current point.
- point_idx  out  CODE_W  0-based index of the current point.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal completion.
- err  out  1  sticky timeout flag. Optional feature only; otherwise tied 0.

Behaviour:
- Reset values: every output is 0 and the FSM is in IDLE. rst overrides all other inputs.
- States: IDLE, APPLY, SETTLE, MEASURE, NEXT, DONE.
- IDLE
  - On go=1, latch cfg_start/cfg_stop/cfg_step/cfg_dwell into internal registers.
  - Set cur=cfg_start and point_idx=0, then go to APPLY.
  - cfg_* changes after that latch have no effect until the next go.
- APPLY (1 cycle)
  - bank_code=cur and bank_en=1 are registered, so they are visible from the cycle after APPLY is entered.
  - Load the dwell counter with max(cfg_dwell,1), then go to SETTLE.
- SETTLE
  - Decrement the counter each cycle and go to MEASURE when it reaches 1.
  - Net effect: exactly max(dwell,1) cycles are spent in SETTLE.
- MEASURE
  - meas_req=1 while in this state.
  - When meas_ack=1 is seen in a cycle with meas_req=1, the point completes; go to NEXT, and meas_req is 0 the following cycle.
  - meas_ack while meas_req=0 is ignored.
- NEXT (1 cycle)
  - Compute nxt = cur + max(step,1) in CODE_W+1 bits.
  - If cur >= stop, or nxt > stop, or nxt overflows CODE_W, go to DONE.
  - Otherwise set cur=nxt, point_idx+=1 (wraps modulo 2^CODE_W) and go to APPLY.
- DONE (1 cycle)
  - done=1, then go to IDLE.
  - bank_code holds its last value; bank_en drops to 0 on entry to IDLE.
- start>stop: exactly one point is measured, at cfg_start.
- abort in any non-IDLE state:
  - Next cycle the FSM is in IDLE with bank_en=0 and meas_req=0.
  - done is not pulsed and point_idx holds.
  - Simultaneous go+abort in IDLE: abort wins and go is ignored.
- go is ignored whenever busy=1.
- Point-count arithmetic is unsigned. Number of points = floor((stop-start)/step)+1 when start<=stop.

Optional Feature:
- Macro: LUMPED_SWEEP_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on MEASURE entry and increments each cycle meas_req=1.
  - If it reaches 2^TO_W-1 without an ack: set err=1 (sticky until rst or the next accepted go), drop meas_req, and go to NEXT. The sweep continues.
  - An ack in the same cycle the counter saturates counts as success.
- Undefined: no counter, MEASURE waits indefinitely, and err is constant 0.

Test Plan:
- Ascending sweep: start=2, stop=10, step=4, dwell=3, ack returned 2 cycles after each req.
  - Expect bank_code sequence 2, 6, 10.
  - Expect point_idx 0, 1, 2.
  - Expect exactly 3 SETTLE cycles before each rising meas_req.
  - Expect one done pulse, then busy=0 and bank_en=0.
- Degenerate settings: start=5, stop=3, step=0, dwell=0.
  - Expect one point at code 5 with 1 settle cycle, then done.
  - Also run start=0, stop=63, step=0 (treated as 1): expect 64 points, final bank_code=63, no wrap past 63.
- Overflow: CODE_W=6, start=60, stop=63, step=5.
  - Expect a single point at 60 (65 overflows), then done.
- Abort during SETTLE at point 1 of the first scenario.
  - Next cycle: IDLE, bank_en=0, meas_req=0, no done pulse.
  - A subsequent go restarts at start=2 with point_idx=0.
- Handshake robustness and go-while-busy:
  - meas_ack pulsed during SETTLE: ignored, no early advance.
  - go asserted mid-sweep: ignored.
  - Mid-sweep rst: all outputs are 0 next cycle.
- With LUMPED_SWEEP_TIMEOUT_EN, TO_W=4, ack never returned on point 1 of the first scenario.
  - err rises 15 cycles after that meas_req.
  - The sweep proceeds to code 10 and finishes with done.
  - err stays 1 until the next go.
